// File: rtl/clint_timer.sv
// clint_timer: core-local interruptor with a free-running 64-bit mtime, a 64-bit
// mtimecmp and a software-interrupt bit.
//
// Ports:
//   clk        system clock, rising edge
//   resetn     asynchronous active-low reset
//   addr       bus address; only addr[15:0] is decoded
//   wdata      full-word store data
//   ren, wen   one-cycle read / write strobes
//   rdata      registered read data (loaded on a ren edge, held otherwise)
//   timer_irq  machine timer interrupt pending (mtime >= mtimecmp), registered
//   soft_irq   machine software interrupt pending (msip), registered
//
// Register map (addr[15:0]):
//   0x0000 msip (bit0)   0x4000/0x4004 mtimecmp lo/hi   0xBFF8/0xBFFC mtime lo/hi
//   A read of 0xBFFC returns the high word latched by the last 0xBFF8 read.
module clint_timer #(
  parameter int unsigned TICK_DIV = 27
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        ren,
  input  logic        wen,
  output logic [31:0] rdata,
  output logic        timer_irq,
  output logic        soft_irq
);

  localparam logic [15:0] AddrMsip     = 16'h0000;
  localparam logic [15:0] AddrMtcmpLo  = 16'h4000;
  localparam logic [15:0] AddrMtcmpHi  = 16'h4004;
  localparam logic [15:0] AddrMtimeLo  = 16'hBFF8;
  localparam logic [15:0] AddrMtimeHi  = 16'hBFFC;
  localparam logic [15:0] PrescMax     = 16'(TICK_DIV - 1);

  logic [15:0] offset;
  logic        unused_addr_hi;

  logic [15:0] presc_q, presc_d;
  logic        tick;
  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic        msip_q, msip_d;
  logic [31:0] hi_shadow_q, hi_shadow_d;
  logic [31:0] rdata_q, rdata_d;
  logic        timer_irq_q, soft_irq_q;

  assign offset         = addr[15:0];
  assign unused_addr_hi = ^addr[31:16];

  // Prescaler runs freely; bus writes never disturb its phase.
  assign tick    = (presc_q == PrescMax);
  assign presc_d = tick ? 16'd0 : presc_q + 16'd1;

  // Register writes. A write to either mtime half overrides that cycle's tick.
  always_comb begin
    mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
    mtimecmp_d = mtimecmp_q;
    msip_d     = msip_q;
    if (wen) begin
      case (offset)
        AddrMsip:    msip_d             = wdata[0];
        AddrMtcmpLo: mtimecmp_d[31:0]   = wdata;
        AddrMtcmpHi: mtimecmp_d[63:32]  = wdata;
        AddrMtimeLo: mtime_d            = {mtime_q[63:32], wdata};
        AddrMtimeHi: mtime_d            = {wdata, mtime_q[31:0]};
        default:     ;
      endcase
    end
  end

  // Reads see pre-write register values; a low mtime read snapshots the high word.
  always_comb begin
    rdata_d     = rdata_q;
    hi_shadow_d = hi_shadow_q;
    if (ren) begin
      case (offset)
        AddrMsip:    rdata_d = {31'd0, msip_q};
        AddrMtcmpLo: rdata_d = mtimecmp_q[31:0];
        AddrMtcmpHi: rdata_d = mtimecmp_q[63:32];
        AddrMtimeLo: begin
          rdata_d     = mtime_q[31:0];
          hi_shadow_d = mtime_q[63:32];
        end
        AddrMtimeHi: rdata_d = hi_shadow_q;
        default:     rdata_d = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      presc_q     <= 16'd0;
      mtime_q     <= 64'd0;
      mtimecmp_q  <= 64'hFFFF_FFFF_FFFF_FFFF;
      msip_q      <= 1'b0;
      hi_shadow_q <= 32'd0;
      rdata_q     <= 32'd0;
      timer_irq_q <= 1'b0;
      soft_irq_q  <= 1'b0;
    end else begin
      presc_q     <= presc_d;
      mtime_q     <= mtime_d;
      mtimecmp_q  <= mtimecmp_d;
      msip_q      <= msip_d;
      hi_shadow_q <= hi_shadow_d;
      rdata_q     <= rdata_d;
      // Compare current register values; the line lags state by one edge.
      timer_irq_q <= (mtime_q >= mtimecmp_q);
      soft_irq_q  <= msip_q;
    end
  end

  assign rdata     = rdata_q;
  assign timer_irq = timer_irq_q;
  assign soft_irq  = soft_irq_q;

endmodule

// File: tb/tb_clint_timer.sv
// Self-checking bench for clint_timer: directed steps from the test plan followed
// by randomized bus traffic, all checked against a cycle-level reference model.
module tb_clint_timer;

  localparam int unsigned TD = 27;

  logic        clk;
  logic        resetn;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ren;
  logic        wen;
  logic [31:0] rdata;
  logic        timer_irq;
  logic        soft_irq;

  int unsigned errors = 0;
  int unsigned checks = 0;

  // Reference model state.
  logic [63:0] m_mtime, m_cmp;
  logic        m_msip;
  logic [31:0] m_shadow, m_rdata;
  logic        m_tirq, m_sirq;
  int unsigned m_n;  // edges since reset release

  clint_timer #(.TICK_DIV(TD)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .addr      (addr),
    .wdata     (wdata),
    .ren       (ren),
    .wen       (wen),
    .rdata     (rdata),
    .timer_irq (timer_irq),
    .soft_irq  (soft_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mtime  = 64'd0;
    m_cmp    = 64'hFFFF_FFFF_FFFF_FFFF;
    m_msip   = 1'b0;
    m_shadow = 32'd0;
    m_rdata  = 32'd0;
    m_tirq   = 1'b0;
    m_sirq   = 1'b0;
    m_n      = 0;
  endtask

  function automatic logic [31:0] m_read(input logic [15:0] off);
    case (off)
      16'h0000: return {31'd0, m_msip};
      16'h4000: return m_cmp[31:0];
      16'h4004: return m_cmp[63:32];
      16'hBFF8: return m_mtime[31:0];
      16'hBFFC: return m_shadow;
      default:  return 32'd0;
    endcase
  endfunction

  // One clock edge: advance the model from the pre-edge inputs, then check outputs.
  task automatic cyc();
    logic        tk;
    logic        n_tirq, n_sirq;
    logic [63:0] nm;
    @(posedge clk);
    tk     = (m_n % TD) == (TD - 1);
    m_n++;
    n_tirq = (m_mtime >= m_cmp);
    n_sirq = m_msip;
    nm     = tk ? m_mtime + 64'd1 : m_mtime;
    if (ren) begin
      m_rdata = m_read(addr[15:0]);
      if (addr[15:0] == 16'hBFF8) m_shadow = m_mtime[63:32];
    end
    if (wen) begin
      case (addr[15:0])
        16'h0000: m_msip        = wdata[0];
        16'h4000: m_cmp[31:0]   = wdata;
        16'h4004: m_cmp[63:32]  = wdata;
        16'hBFF8: nm            = {m_mtime[63:32], wdata};
        16'hBFFC: nm            = {wdata, m_mtime[31:0]};
        default:  ;
      endcase
    end
    m_mtime = nm;
    m_tirq  = n_tirq;
    m_sirq  = n_sirq;
    #1;
    chk("rdata", 64'(rdata), 64'(m_rdata));
    chk("timer_irq", 64'(timer_irq), 64'(m_tirq));
    chk("soft_irq", 64'(soft_irq), 64'(m_sirq));
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr = a; wdata = d; wen = 1'b1;
    cyc();
    wen = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    addr = a; ren = 1'b1;
    cyc();
    ren = 1'b0;
    d = rdata;
  endtask

  task automatic timeout(input string tag);
    checks++;
    errors++;
    $error("FAIL %s: observed=timeout expected=event", tag);
  endtask

  initial begin
    logic [31:0] d;
    logic [15:0] offs [6];
    int k;
    offs[0] = 16'h0000; offs[1] = 16'h4000; offs[2] = 16'h4004;
    offs[3] = 16'hBFF8; offs[4] = 16'hBFFC; offs[5] = 16'h1234;

    resetn = 1'b0; addr = '0; wdata = '0; ren = 1'b0; wen = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rdata", 64'(rdata), 64'd0);
    chk("reset_timer_irq", 64'(timer_irq), 64'd0);
    chk("reset_soft_irq", 64'(soft_irq), 64'd0);
    resetn = 1'b1;

    // Free-run: 270 edges at TICK_DIV=27 gives 10 ticks.
    repeat (270) cyc();
    rd(32'h0000_BFF8, d);
    chk("free_run_lo_in_9_to_11", 64'((d >= 32'd9) && (d <= 32'd11)), 64'd1);
    rd(32'h0000_BFFC, d);
    chk("free_run_hi", 64'(d), 64'd0);

    // Compare and interrupt.
    wr(32'h0000_BFFC, 32'd0);
    wr(32'h0000_BFF8, 32'd0);
    wr(32'h0000_4004, 32'd0);
    wr(32'h0000_4000, 32'd5);
    for (k = 0; k < 300 && m_mtime != 64'd5; k++) cyc();
    if (k >= 300) timeout("wait_mtime_5");
    chk("cmp_irq_not_yet", 64'(timer_irq), 64'd0);
    cyc();
    chk("cmp_irq_asserted", 64'(timer_irq), 64'd1);
    wr(32'h0000_4000, 32'hFFFF_FFFF);
    chk("cmp_irq_still_on_write_edge", 64'(timer_irq), 64'd1);
    cyc();
    chk("cmp_irq_deasserted", 64'(timer_irq), 64'd0);

    // Wrap and shadow.
    wr(32'h0000_BFFC, 32'd0);
    wr(32'h0000_BFF8, 32'hFFFF_FFFF);
    for (k = 0; k < 60 && m_mtime != 64'h1_0000_0000; k++) cyc();
    if (k >= 60) timeout("wait_wrap");
    rd(32'h0000_BFF8, d);
    chk("wrap_lo", 64'(d), 64'd0);
    rd(32'h0000_BFFC, d);
    chk("wrap_hi", 64'(d), 64'd1);
    wr(32'h0000_BFFC, 32'd7);
    rd(32'h0000_BFFC, d);
    chk("shadow_hold", 64'(d), 64'd1);

    // Write colliding with a tick: the increment is lost.
    for (k = 0; k < 60 && (m_n % TD) != (TD - 1); k++) cyc();
    if (k >= 60) timeout("wait_tick_align");
    wr(32'h0000_BFF8, 32'd100);
    rd(32'h0000_BFF8, d);
    chk("collision_lo", 64'(d), 64'd100);
    repeat (TD) cyc();
    rd(32'h0000_BFF8, d);
    chk("collision_next_tick", 64'(d), 64'd101);

    // Software interrupt and unmapped access.
    wr(32'h0000_0000, 32'hFFFF_FFFF);
    chk("msip_lag", 64'(soft_irq), 64'd0);
    rd(32'h0000_0000, d);
    chk("msip_read", 64'(d), 64'd1);
    chk("msip_irq_set", 64'(soft_irq), 64'd1);
    wr(32'h0000_0000, 32'd0);
    cyc();
    chk("msip_irq_clear", 64'(soft_irq), 64'd0);
    rd(32'h0000_1234, d);
    chk("unmapped_read", 64'(d), 64'd0);

    // Randomized traffic, including simultaneous read+write and aliased upper bits.
    for (int i = 0; i < 600; i++) begin
      addr[31:16] = 16'($urandom());
      addr[15:0]  = ($urandom_range(0, 9) == 0) ? 16'($urandom()) : offs[$urandom_range(0, 5)];
      wdata = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 40)) : $urandom();
      ren   = ($urandom_range(0, 2) == 0);
      wen   = ($urandom_range(0, 3) == 0);
      cyc();
      ren = 1'b0;
      wen = 1'b0;
      if ($urandom_range(0, 1) == 0) cyc();
    end

    // Async reset mid-run with both interrupts pending.
    wr(32'h0000_4004, 32'd0);
    wr(32'h0000_4000, 32'd0);
    wr(32'h0000_0000, 32'd1);
    rd(32'h0000_0000, d);
    cyc();
    chk("pre_reset_timer_irq", 64'(timer_irq), 64'd1);
    chk("pre_reset_soft_irq", 64'(soft_irq), 64'd1);
    #2 resetn = 1'b0;
    #1;
    chk("async_reset_timer_irq", 64'(timer_irq), 64'd0);
    chk("async_reset_soft_irq", 64'(soft_irq), 64'd0);
    chk("async_reset_rdata", 64'(rdata), 64'd0);
    model_reset();
    @(posedge clk);
    #1 resetn = 1'b1;
    rd(32'h0000_4000, d);
    chk("post_reset_cmp_lo", 64'(d), 64'hFFFF_FFFF);
    rd(32'h0000_4004, d);
    chk("post_reset_cmp_hi", 64'(d), 64'hFFFF_FFFF);
    rd(32'h0000_BFFC, d);
    chk("post_reset_shadow", 64'(d), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
